// File: rtl/score_panel_if.sv
// score_panel bus: game-state inputs, beam position, pixel and status outputs.
// The master drives state and beam; the slave (score_panel) returns pixels.
interface score_panel_if #(
  parameter int COLOR_BITS  = 24,
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_BITS  = 14
);
  localparam int CH = COLOR_BITS / 3;

  logic [3:0]                        level_i;
  logic [NUM_PLAYERS*SCORE_BITS-1:0] score_i;
  logic [9:0]                        hpos_i;
  logic [9:0]                        vpos_i;
  logic [CH-1:0]                     text_blue_o;
  logic [CH-1:0]                     text_green_o;
  logic [CH-1:0]                     text_red_o;
  logic                              text_enable_o;
  logic                              bcd_valid_o;
  logic                              busy_o;

  modport master (
    output level_i, score_i, hpos_i, vpos_i,
    input  text_blue_o, text_green_o, text_red_o,
    input  text_enable_o, bcd_valid_o, busy_o
  );

  modport slave (
    input  level_i, score_i, hpos_i, vpos_i,
    output text_blue_o, text_green_o, text_red_o,
    output text_enable_o, bcd_valid_o, busy_o
  );
endinterface

// File: rtl/score_panel.sv
// Side-panel text renderer: level row plus one score row per player.
// Scores go through a shared sequential double-dabble engine.

// Compact procedural glyph set: character code in the low six bits,
// a line-dependent stripe pattern in the top two bits.
module ascii_rom (
  input  logic [9:0] addr_i,
  output logic [7:0] data_o
);
  assign data_o = {addr_i[1:0] ^ addr_i[3:2], addr_i[9:4]};
endmodule

module score_panel #(
  parameter int COLOR_BITS   = 24,
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_BITS   = 14,
  parameter int DIGITS       = 4,
  parameter int FLASH_FRAMES = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  score_panel_if.slave bus
);
  localparam int CH = COLOR_BITS / 3;
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int BW = 4 * DIGITS;
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int CW = $clog2(SCORE_BITS + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;
  localparam logic [CH-1:0] BG = {3'b111, {(CH-3){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d, ptr_nxt;
  logic [SCORE_BITS-1:0] shreg_q, shreg_d;
  logic [SCORE_BITS-1:0] snap_q, snap_d;
  logic [BW-1:0]         bcd_q, bcd_d, dab;
  logic                  sat_q, sat_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  store;

  logic [BW-1:0]          digits_q [NUM_PLAYERS];
  logic [SCORE_BITS-1:0]  last_q   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] conv_done_q;

  logic [SCORE_BITS-1:0] score_sel;
  logic                  over;
  logic [BW-1:0]         new_dig;

  assign score_sel = bus.score_i[int'(ptr_q)*SCORE_BITS +: SCORE_BITS];
  assign over      = {{(64-SCORE_BITS){1'b0}}, score_sel} > MAXV;
  assign ptr_nxt   = (ptr_q == PW'(NUM_PLAYERS-1)) ? '0 : ptr_q + 1'b1;
  assign new_dig   = sat_q ? {DIGITS{4'h9}} : bcd_q;

  // Add-3 correction on every BCD nibble of five or more.
  always_comb begin
    dab = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        dab[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Converter next state: round-robin scan, load, shift, store.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    shreg_d = shreg_q;
    snap_d  = snap_q;
    bcd_d   = bcd_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    store   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (score_sel != last_q[ptr_q] || !conv_done_q[ptr_q])
          state_d = LOAD;
        else
          ptr_d = ptr_nxt;
      end
      LOAD: begin
        snap_d  = score_sel;
        shreg_d = score_sel;
        bcd_d   = '0;
        cnt_d   = '0;
        sat_d   = over;
        state_d = over ? STORE : SHIFT;
      end
      SHIFT: begin
        bcd_d   = {dab[BW-2:0], shreg_q[SCORE_BITS-1]};
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(SCORE_BITS-1))
          state_d = STORE;
      end
      STORE: begin
        store   = 1'b1;
        ptr_d   = ptr_nxt;
        state_d = IDLE;
      end
    endcase
  end

  // Converter state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      shreg_q <= '0;
      snap_q  <= '0;
      bcd_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      shreg_q <= shreg_d;
      snap_q  <= snap_d;
      bcd_q   <= bcd_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-row results written back on STORE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        digits_q[p] <= '0;
        last_q[p]   <= '0;
      end
      conv_done_q <= '0;
    end else if (store) begin
      digits_q[ptr_q]    <= new_dig;
      last_q[ptr_q]      <= snap_q;
      conv_done_q[ptr_q] <= 1'b1;
    end
  end

  logic [3:0]           level_q;
  logic                 zero_q;
  logic                 at_zero;
  logic                 tick;
  logic [NUM_PLAYERS:0] trig;
  logic [NUM_PLAYERS:0] sup_v;
  logic [FW-1:0]        flash_q [NUM_PLAYERS+1];

  assign at_zero = (bus.hpos_i == 10'd0) && (bus.vpos_i == 10'd0);
  assign tick    = at_zero && !zero_q;

  // Blink triggers: index 0 is the level row, 1+p the score rows.
  always_comb begin
    trig    = '0;
    trig[0] = bus.level_i != level_q;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      trig[p+1] = store && (ptr_q == PW'(p)) &&
                  (new_dig != digits_q[p]);
    end
    for (int i = 0; i <= NUM_PLAYERS; i++)
      sup_v[i] = (flash_q[i] != '0) && flash_q[i][2];
  end

  // Level copy and frame-start edge detector.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= bus.level_i;
      zero_q  <= 1'b0;
    end else begin
      level_q <= bus.level_i;
      zero_q  <= at_zero;
    end
  end

  // Blink counters: reload on trigger, count frames down to zero.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i <= NUM_PLAYERS; i++) begin
      if (rst_i)
        flash_q[i] <= '0;
      else if (trig[i])
        flash_q[i] <= FW'(FLASH_FRAMES);
      else if (tick && flash_q[i] != '0)
        flash_q[i] <= flash_q[i] - 1'b1;
    end
  end

  logic [5:0] col;
  logic [4:0] row;
  int         idx;
  logic       cell_in;
  logic       cell_sup;
  logic [5:0] code;

  assign col = bus.hpos_i[9:4];
  assign row = bus.vpos_i[9:5];
  assign idx = int'(col) - 29;

  // Cell decode: which text cell the beam is in and its glyph code.
  always_comb begin
    cell_in  = 1'b0;
    cell_sup = 1'b0;
    code     = 6'd0;
    if (row == 5'd10 && col >= 6'd29 && col <= 6'd35) begin
      cell_in  = 1'b1;
      cell_sup = sup_v[0];
      case (idx)
        0, 4:    code = 6'd22;
        1, 3:    code = 6'd15;
        2:       code = 6'd32;
        5:       code = 6'd37;
        default: code = {2'b00, bus.level_i} + 6'd1;
      endcase
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (row == 5'(11+p) && col >= 6'd29 &&
          col <= 6'(31+DIGITS)) begin
        cell_in  = 1'b1;
        cell_sup = sup_v[p+1];
        if (idx == 0)
          code = 6'd26;
        else if (idx == 1)
          code = 6'(p+2);
        else if (idx == 2)
          code = 6'd37;
        else
          code = {2'b00,
                  digits_q[p][4*(DIGITS+2-idx) +: 4]} + 6'd1;
      end
    end
  end

  logic       s1_in_q;
  logic       s1_sup_q;
  logic [9:0] s1_addr_q;
  logic [2:0] s1_sel_q;
  logic [7:0] rom_data;
  logic       pix_on;
  logic       unused_pos;

  assign unused_pos = &{1'b0, bus.hpos_i[0], bus.vpos_i[0]};

  // Stage 1: cell decode and glyph address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_in_q   <= 1'b0;
      s1_sup_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_sel_q  <= '0;
    end else begin
      s1_in_q   <= cell_in;
      s1_sup_q  <= cell_sup;
      s1_addr_q <= {code, bus.vpos_i[4:1]};
      s1_sel_q  <= ~bus.hpos_i[3:1];
    end
  end

  ascii_rom u_rom (
    .addr_i (s1_addr_q),
    .data_o (rom_data)
  );

  assign pix_on = rom_data[s1_sel_q] & ~s1_sup_q;

  logic          en_q, en_d;
  logic [CH-1:0] rgb_q, rgb_d;

  // Stage 2 colour: ink is black, background light grey.
  always_comb begin
    en_d  = s1_in_q;
    rgb_d = '0;
    if (s1_in_q && !pix_on)
      rgb_d = BG;
  end

  // Stage 2: registered pixel outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      en_q  <= en_d;
      rgb_q <= rgb_d;
    end
  end

  assign bus.text_enable_o = en_q;
  assign bus.text_red_o    = rgb_q;
  assign bus.text_green_o  = rgb_q;
  assign bus.text_blue_o   = rgb_q;
  assign bus.bcd_valid_o   = &conv_done_q;
  assign bus.busy_o        = state_q != IDLE;
endmodule

// File: doc/score_panel.md
# score_panel

Parametrised, registered successor to the score board text renderer: draws a "LEVEL n" row plus one "Pn dddd" score row per player in the side panel, converting binary scores to decimal with a shared sequential double-dabble engine instead of combinational dividers. It sits between the game-state registers and the VGA pixel mux. It adds a 2-stage pixel pipeline, score saturation, and per-row blink on change.

## Interface
- COLOR_BITS, 24, total RGB bits; each channel is COLOR_BITS/3.
- NUM_PLAYERS, 2, number of score rows; legal range 1–4.
- SCORE_BITS, 14, width of each binary score.
- DIGITS, 4, decimal digits shown per score.
- FLASH_FRAMES, 32, blink duration in frames after a change; must be a multiple of 8.

- clk_i  in  1  pixel clock; one pixel per cycle.
- rst_i  in  1  synchronous, active-high reset.
- level_i  in  4  current level, 0–9.
- score_i  in  NUM_PLAYERS*SCORE_BITS  player p occupies [p*SCORE_BITS +: SCORE_BITS].
- hpos_i, vpos_i  in  10 each  beam position.
- text_blue_o, text_green_o, text_red_o  out  COLOR_BITS/3 each  pixel colour.
- text_enable_o  out  1  pixel lies inside a text cell.
- bcd_valid_o  out  1  every score row has been converted at least once since reset.
- busy_o  out  1  conversion FSM is not IDLE.

## Operation
- Cells are 16×32 pixels. Column is hpos_i[9:4]; row is vpos_i[9:5].
- Level row:
  - Placed at row 10, columns 29–35.
  - Shows codes L=22, E=15, V=32, E, L, space=37, then 1+level_i.
- Score row for player p:
  - Placed at row 11+p, columns 29 to 31+DIGITS.
  - Shows P=26, digit code 1+(p+1), space, then DIGITS digit codes 1+d, most significant digit first.
- Glyph lookup:
  - ascii_rom address is {code[5:0], vpos_i[4:1]}.
  - Bit select is ~hpos_i[3:1].
  - Glyph bit 1 gives colour 0; glyph bit 0 gives background 24'hE0E0E0.
- Converter FSM, round-robin over players using pointer ptr:
  - IDLE: compare score_i[ptr] with last_bin[ptr]. If different, or the row was never converted, go to LOAD. Otherwise advance ptr (wrapping at NUM_PLAYERS-1) and stay in IDLE.
  - LOAD: snapshot score to shreg. If the value is greater than 10^DIGITS−1, set sat and go to STORE. Otherwise clear the BCD accumulator and go to SHIFT.
  - SHIFT: run SCORE_BITS iterations, one cycle each. Each iteration adds 3 to every nibble ≥5, then shifts left by 1. Then go to STORE.
  - STORE:
    - Write the digits to digits[ptr]; if sat, write all 9s.
    - Write the snapshot to last_bin[ptr] and set conv_done[ptr].
    - If the digits differ from the previous digits, start the flash for row ptr.
    - Advance ptr and return to IDLE.
- If the score changes mid-conversion, the snapshot is still used; the next visit to that row catches the new value.
- Flash:
  - Frame tick is a one-cycle pulse when (hpos_i,vpos_i)==(0,0) and the previous cycle's position was not (0,0).
  - Each row has a counter. It reloads to FLASH_FRAMES on trigger, reloading again if already running, and decrements on every frame tick while nonzero.
  - While the counter is nonzero and counter[2]==1, glyph bits are forced to 0 (background only). text_enable_o stays 1.
  - Level flash triggers when level_i differs from its registered copy.

## Timing
- Reset values:
  - All outputs 0.
  - digits 0; last_bin 0; conv_done 0; flash counters 0.
  - FSM IDLE; ptr 0.
  - Level copy loads level_i, so no flash occurs after reset.
- Pixel path latency is 2 cycles from hpos_i/vpos_i to colour and enable.
  - Stage 1 registers the cell decode and ROM address.
  - Stage 2 registers the ROM bit and colour.
- Conversion latency per changed row is SCORE_BITS+2 cycles (LOAD, SHIFT×SCORE_BITS, STORE). A saturated value takes 2 cycles.
- An unchanged row costs 1 IDLE cycle.
- bcd_valid_o rises in the cycle after the STORE that sets the last conv_done bit, and stays high until reset.
- Digit register updates take effect on the display at the next pixel fetch. Tearing within a frame is acceptable.
- Reset asserted mid-SHIFT aborts the conversion. digits are left at 0 and the FSM restarts from ptr 0.

## Test plan
- After reset with all scores 0: bcd_valid_o goes high within NUM_PLAYERS*(SCORE_BITS+3) cycles, and row 11 renders codes 26,2,37,1,1,1,1.
- score_i[p0]=1234: after 16 cycles digits[0]=1,2,3,4, and the pixel at column 32 row 11 uses code 2.
- score_i[p1]=12000 (above 9999): digits[1]=9,9,9,9 after 2 cycles, and the row 12 flash counter loads 32.
- Drive level_i from 3 to 4, then run 32 frame ticks: level row glyphs are suppressed for 4 groups of 4 frames, then show code 5.
- Change p0's score during SHIFT: the first STORE holds the old snapshot, and a second conversion follows within one round-robin sweep.
- Apply a pixel at (464,320): colour appears exactly 2 clocks later; off-panel pixels give enable 0 and colour 0.
